// File: rtl/bytes_to_dibits_if.sv
// Byte-in / dibit-out bus of the transmit serializer.
// slave is the serializer side, master is the byte source and dibit sink.
interface bytes_to_dibits_if;
  logic       inclk;
  logic [7:0] in;
  logic       done_in;
  logic       in_ready;
  logic [1:0] out;
  logic       outclk;
  logic       done_out;
  logic       overflow;
  logic       busy;

  modport slave (
    input  inclk, in, done_in,
    output in_ready, out, outclk, done_out, overflow, busy
  );

  modport master (
    output inclk, in, done_in,
    input  in_ready, out, outclk, done_out, overflow, busy
  );
endinterface

// File: rtl/bytes_to_dibits.sv
// Serializes bytes from a 2-entry FIFO into a paced dibit stream, LSB dibit first.
// A byte's done marker rides along and pulses done_out with that byte's final dibit.
module bytes_to_dibits #(
  parameter int DIBIT_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset,
  bytes_to_dibits_if.slave  bus
);
  localparam int PW = (DIBIT_PERIOD > 1) ? $clog2(DIBIT_PERIOD) : 1;
  localparam logic [PW-1:0] PACE_LAST = PW'(DIBIT_PERIOD - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef struct packed {
    logic       done;
    logic [7:0] data;
  } entry_t;

  entry_t        mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  state_t        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic          done_flag_q, done_flag_d;
  logic [PW-1:0] pace_q, pace_d;
  logic [1:0]    dcnt_q, dcnt_d;
  logic [1:0]    out_q, out_d;
  logic          outclk_q, outclk_d;
  logic          done_out_q, done_out_d;
  logic          overflow_q;
  logic          push, pop;
  entry_t        head;

  assign bus.in_ready = !reset && (count_q != 2'd2);
  assign push         = bus.inclk && bus.in_ready;
  assign head         = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    done_flag_d = done_flag_q;
    pace_d      = pace_q;
    dcnt_d      = dcnt_q;
    out_d       = out_q;
    outclk_d    = 1'b0;
    done_out_d  = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop         = 1'b1;
          sh_d        = head.data;
          done_flag_d = head.done;
          pace_d      = '0;
          dcnt_d      = 2'd0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        pace_d = (pace_q == PACE_LAST) ? '0 : pace_q + PW'(1);
        if (pace_q == '0) begin
          out_d    = sh_q[1:0];
          outclk_d = 1'b1;
          sh_d     = sh_q >> 2;
          dcnt_d   = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            done_out_d = done_flag_q;
            // Refill on the last emission so the next byte keeps the same pacing.
            if (count_q != 2'd0) begin
              pop         = 1'b1;
              sh_d        = head.data;
              done_flag_d = head.done;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= 8'd0;
      done_flag_q <= 1'b0;
      pace_q      <= '0;
      dcnt_q      <= 2'd0;
      out_q       <= 2'd0;
      outclk_q    <= 1'b0;
      done_out_q  <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      done_flag_q <= done_flag_d;
      pace_q      <= pace_d;
      dcnt_q      <= dcnt_d;
      out_q       <= out_d;
      outclk_q    <= outclk_d;
      done_out_q  <= done_out_d;
      overflow_q  <= bus.inclk && !bus.in_ready;
      count_q     <= count_q + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.done_in, bus.in};
  end

  assign bus.out      = out_q;
  assign bus.outclk   = outclk_q;
  assign bus.done_out = done_out_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != IDLE) || (count_q != 2'd0);
endmodule
